// File: rtl/keypad_cmd_encoder.sv
// Scans a 4x4 active-low keypad, debounces a single pressed key and emits its
// calculator command code as a fixed-length cmd/cmd_valid burst.
module keypad_cmd_encoder #(
  parameter int SCAN_DIV    = 4,
  parameter int DEBOUNCE    = 3,
  parameter int HOLD_CYCLES = 10
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] rows,
  input  logic [3:0] cols,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       key_down
);
  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [3:0] NOP_CODE = 4'b1111;
  localparam logic [3:0] KEY_D    = 4'd15;

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_EMIT, ST_RELEASE} state_t;

  logic [3:0]        col_s1_q, col_s2_q;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        row_q;
  logic [3:0]        rows_q;
  logic [11:0]       frame_q;
  state_t            state_q;
  logic [3:0]        cand_q;
  logic [DEB_W-1:0]  deb_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [3:0]        cmd_q;
  logic              cmd_valid_q;
  logic              key_down_q;

  logic              sample_s;
  logic              frame_end_s;
  logic [15:0]       frame_s;
  logic [4:0]        key_cnt_s;
  logic [3:0]        key_idx_s;
  logic              key_vld_s;
  logic              deb_done_s;
  logic              accept_s;

  function automatic logic [3:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:    key_code = 4'd1;
      4'd1:    key_code = 4'd2;
      4'd2:    key_code = 4'd3;
      4'd3:    key_code = 4'b1010;
      4'd4:    key_code = 4'd4;
      4'd5:    key_code = 4'd5;
      4'd6:    key_code = 4'd6;
      4'd7:    key_code = 4'b1011;
      4'd8:    key_code = 4'd7;
      4'd9:    key_code = 4'd8;
      4'd10:   key_code = 4'd9;
      4'd11:   key_code = 4'b1100;
      4'd12:   key_code = 4'b1101;
      4'd13:   key_code = 4'd0;
      4'd14:   key_code = 4'b1110;
      default: key_code = NOP_CODE;
    endcase
  endfunction

  // Row3 columns are taken live from the synchroniser so the frame is judged on its last sample.
  always_comb begin
    sample_s    = (div_q == DIV_W'(SCAN_DIV - 1));
    frame_end_s = sample_s && (row_q == 2'd3);
    frame_s     = {~col_s2_q, frame_q};
    key_cnt_s   = 5'd0;
    key_idx_s   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_s[i]) begin
        key_cnt_s = key_cnt_s + 5'd1;
        key_idx_s = 4'(i);
      end else begin
        key_cnt_s = key_cnt_s;
      end
    end
    key_vld_s  = (key_cnt_s == 5'd1);
    deb_done_s = ((int'(deb_cnt_q) + 32'sd1) >= DEBOUNCE);
    accept_s   = frame_end_s && key_vld_s &&
                 (((state_q == ST_SCAN) && (DEBOUNCE == 1)) ||
                  ((state_q == ST_DEBOUNCE) && (key_idx_s == cand_q) && deb_done_s));
  end

  // Column synchroniser, free-running row scan and per-row frame capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
      div_q    <= '0;
      row_q    <= 2'd0;
      rows_q   <= 4'b1110;
      frame_q  <= 12'h000;
    end else begin
      col_s1_q <= cols;
      col_s2_q <= col_s1_q;
      if (sample_s) begin
        div_q  <= '0;
        row_q  <= row_q + 2'd1;
        rows_q <= {rows_q[2:0], rows_q[3]};
        case (row_q)
          2'd0:    frame_q[3:0]  <= ~col_s2_q;
          2'd1:    frame_q[7:4]  <= ~col_s2_q;
          2'd2:    frame_q[11:8] <= ~col_s2_q;
          default: frame_q       <= frame_q;
        endcase
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  // Press/release debounce and command burst FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SCAN;
      cand_q      <= 4'd0;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      cmd_q       <= NOP_CODE;
      cmd_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else if (accept_s) begin
      key_down_q <= 1'b1;
      deb_cnt_q  <= '0;
      cand_q     <= key_idx_s;
      if (key_idx_s == KEY_D) begin
        state_q <= ST_RELEASE;
      end else begin
        state_q     <= ST_EMIT;
        cmd_q       <= key_code(key_idx_s);
        cmd_valid_q <= 1'b1;
        hold_cnt_q  <= HOLD_W'(1);
      end
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (frame_end_s && key_vld_s) begin
            cand_q    <= key_idx_s;
            deb_cnt_q <= DEB_W'(1);
            state_q   <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (frame_end_s) begin
            if (!key_vld_s) begin
              deb_cnt_q <= '0;
              state_q   <= ST_SCAN;
            end else if (key_idx_s != cand_q) begin
              cand_q    <= key_idx_s;
              deb_cnt_q <= DEB_W'(1);
            end else if (deb_cnt_q != DEB_W'(DEBOUNCE)) begin
              deb_cnt_q <= deb_cnt_q + DEB_W'(1);
            end
          end
        end
        ST_EMIT: begin
          if (hold_cnt_q >= HOLD_W'(HOLD_CYCLES)) begin
            cmd_q       <= NOP_CODE;
            cmd_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            state_q     <= ST_RELEASE;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_RELEASE: begin
          if (frame_end_s) begin
            if (key_vld_s) begin
              deb_cnt_q <= '0;
            end else if (deb_done_s) begin
              deb_cnt_q  <= '0;
              key_down_q <= 1'b0;
              state_q    <= ST_SCAN;
            end else begin
              deb_cnt_q <= deb_cnt_q + DEB_W'(1);
            end
          end
        end
        default: state_q <= ST_SCAN;
      endcase
    end
  end

  assign rows      = rows_q;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign key_down  = key_down_q;
endmodule

// File: tb/tb_keypad_cmd_encoder.sv
// Bench for keypad_cmd_encoder: keypad matrix model plus a burst scoreboard
// fed by the scenario tasks.
module tb_keypad_cmd_encoder;
  localparam int HOLD = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic        key_down;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  always #5 clock = ~clock;

  keypad_cmd_encoder dut (
    .clock    (clock),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .key_down (key_down)
  );

  // A pressed key pulls its column low while its row is driven low.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && keys[4*r+c]) cols[c] = 1'b0;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic monitor();
    bit         in_burst;
    int         len;
    logic [3:0] code;
    logic [3:0] exp;
    in_burst = 1'b0;
    len = 0;
    code = 4'hF;
    forever begin
      @(negedge clock);
      if (!reset) begin
        in_burst = 1'b0;
      end else if (cmd_valid) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          len = 1;
          code = cmd;
        end else begin
          len++;
          checks++;
          if (cmd !== code) begin
            errors++;
            $display("FAIL cmd_stable: got %h, need %h", cmd, code);
          end
        end
      end else begin
        checks++;
        if (cmd !== 4'hF) begin
          errors++;
          $display("FAIL cmd_idle: got %h, need f", cmd);
        end
        if (in_burst) begin
          in_burst = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_burst: got code %h, need none", code);
          end else begin
            exp = exp_q.pop_front();
            if (code !== exp) begin
              errors++;
              $display("FAIL burst_code: got %h, need %h", code, exp);
            end
          end
          checks++;
          if (len != HOLD) begin
            errors++;
            $display("FAIL burst_len: got %0d, need %0d", len, HOLD);
          end
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_burst: got %0d pending, need 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_key_down(input string name, input logic need);
    checks++;
    if (key_down !== need) begin
      errors++;
      $display("FAIL %s_key_down: got %b, need %b", name, key_down, need);
    end
  endtask

  task automatic test_reset();
    keys = 16'h0000;
    reset = 1'b0;
    wait_cycles(3);
    checks++;
    if (rows !== 4'b1110) begin errors++; $display("FAIL reset_rows: got %b, need 1110", rows); end
    checks++;
    if (cmd !== 4'b1111) begin errors++; $display("FAIL reset_cmd: got %b, need 1111", cmd); end
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b, need 0", cmd_valid); end
    check_key_down("reset", 1'b0);
    reset = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_single_key();
    bit found;
    int lat;
    found = 1'b0;
    lat = 0;
    keys = 16'h0001;
    exp_q.push_back(4'd1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!found && cmd_valid) begin
        found = 1'b1;
        lat = i + 1;
      end
    end
    checks++;
    if (!found || lat > 64) begin
      errors++;
      $display("FAIL press_latency: got found=%0d lat=%0d, need lat<=64", found, lat);
    end
    check_key_down("single_held", 1'b1);
    keys = 16'h0000;
    wait_cycles(80);
    check_key_down("single_released", 1'b0);
    check_drained("single");
  endtask

  task automatic test_sequence();
    logic [15:0] masks[3];
    logic [3:0]  codes[3];
    masks = '{16'h0800, 16'h0004, 16'h4000};
    codes = '{4'b1100, 4'd3, 4'b1110};
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(codes[k]);
      keys = masks[k];
      wait_cycles(80);
      check_key_down("seq_held", 1'b1);
      keys = 16'h0000;
      wait_cycles(80);
      check_key_down("seq_released", 1'b0);
    end
    check_drained("sequence");
  endtask

  task automatic test_bounce();
    bit saw;
    saw = 1'b0;
    for (int f = 0; f < 10; f++) begin
      keys = (f % 2 == 0) ? 16'h0020 : 16'h0000;
      for (int i = 0; i < 16; i++) begin
        @(negedge clock);
        if (cmd_valid) saw = 1'b1;
      end
    end
    checks++;
    if (saw) begin errors++; $display("FAIL bounce_no_burst: got cmd_valid=1, need 0"); end
    exp_q.push_back(4'd5);
    keys = 16'h0020;
    wait_cycles(100);
    keys = 16'h0000;
    wait_cycles(80);
    check_drained("bounce");
  endtask

  task automatic test_ghost();
    bit saw;
    saw = 1'b0;
    keys = 16'h0042;
    for (int i = 0; i < 160; i++) begin
      @(negedge clock);
      if (cmd_valid) saw = 1'b1;
    end
    checks++;
    if (saw) begin errors++; $display("FAIL ghost_no_burst: got cmd_valid=1, need 0"); end
    check_key_down("ghost", 1'b0);
    exp_q.push_back(4'd2);
    keys = 16'h0002;
    wait_cycles(100);
    keys = 16'h0000;
    wait_cycles(80);
    check_drained("ghost");
  endtask

  task automatic test_key_d();
    bit bad;
    bad = 1'b0;
    keys = 16'h8000;
    for (int i = 0; i < 160; i++) begin
      @(negedge clock);
      if (cmd_valid || cmd !== 4'b1111) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL key_d_no_cmd: got cmd/cmd_valid activity, need idle"); end
    check_key_down("key_d_held", 1'b1);
    keys = 16'h0000;
    wait_cycles(80);
    check_key_down("key_d_released", 1'b0);
  endtask

  task automatic test_reset_mid_emit();
    bit found;
    found = 1'b0;
    keys = 16'h2000;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clock);
      if (cmd_valid) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_emit_start: got no burst, need burst within 100 cycles"); end
    wait_cycles(3);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (cmd !== 4'b1111) begin errors++; $display("FAIL async_reset_cmd: got %b, need 1111", cmd); end
    checks++;
    if (cmd_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b, need 0", cmd_valid); end
    wait_cycles(3);
    check_key_down("mid_emit_reset", 1'b0);
    reset = 1'b1;
    exp_q.push_back(4'd0);
    wait_cycles(100);
    keys = 16'h0000;
    wait_cycles(80);
    check_drained("mid_emit");
  endtask

  initial begin
    keys = 16'h0000;
    reset = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_key();
    test_sequence();
    test_bounce();
    test_ghost();
    test_key_d();
    test_reset_mid_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_cmd_encoder.md
# keypad_cmd_encoder

Front-end command source for the calculator: scans a 4x4 active-low matrix keypad, debounces the pressed key, and produces the 4-bit `cmd` code consumed by `calc_top`. It drives each recognised keypress as one `cmd` burst held for a fixed number of cycles, then returns `cmd` to the NOP code. It sits between the board keypad pins and `calc_top.cmd`, in the same `clock` domain.

## Interface
Parameters:
- `SCAN_DIV`, default 4: cycles each row is driven (minimum 3).
- `DEBOUNCE`, default 3: consecutive identical scan frames needed to accept a press or a release (minimum 1).
- `HOLD_CYCLES`, default 10: cycles `cmd` and `cmd_valid` stay asserted per keypress (minimum 1).

Ports:
- `clock`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rows`  out  4  keypad row drive, active-low one-hot.
- `cols`  in  4  keypad column sense, active-low, asynchronous to `clock`.
- `cmd`  out  4  command code to `calc_top`.
- `cmd_valid`  out  1  high while `cmd` carries a keypress.
- `key_down`  out  1  high from press acceptance until release acceptance.

## Operation
- Key map (row r, col c; key index = 4r+c):
  - row0: 1, 2, 3, A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: *, 0, #, D
- Codes:
  - digits 0–9 → 4'd0–4'd9
  - A → 4'b1010 (add)
  - B → 4'b1011 (sub)
  - C → 4'b1100 (mul)
  - \* → 4'b1101 (clear)
  - \# → 4'b1110 (equals)
  - D → no command
  - NOP/idle → 4'b1111
- Scanning:
  - `cols` passes through a 2-FF synchroniser.
  - A row counter advances every `SCAN_DIV` cycles, sequence row0..row3, wrapping to row0.
  - `rows` is the one-hot-low of the current row.
  - Synchronised `cols` are sampled on the last cycle of each row window.
  - Scanning never stops, including during emit and reset release.
- Frame result, evaluated after the row3 sample:
  - exactly one key low in the frame → that key index;
  - zero keys, or two or more keys (ghosting) → NONE.
- FSM states:
  - SCAN: waits for a valid key frame.
  - DEBOUNCE: counts consecutive frames equal to the candidate key.
    - A differing frame (another key or NONE) restarts the count: a new key becomes the candidate; NONE returns to SCAN.
    - When the count reaches `DEBOUNCE`, the key is accepted and `key_down` is set.
    - Accepted key D goes straight to RELEASE; every other key goes to EMIT.
  - EMIT: drives `cmd` = code and `cmd_valid` = 1 for exactly `HOLD_CYCLES` cycles, then `cmd` = 4'b1111 and `cmd_valid` = 0, and goes to RELEASE.
  - RELEASE: requires `DEBOUNCE` consecutive NONE frames, then clears `key_down` and returns to SCAN. Any key frame restarts the count. A held key is never re-emitted.
- Outside EMIT, `cmd` = 4'b1111 and `cmd_valid` = 0.
- Counter widths: $clog2 of each parameter's range (plus 1 where needed). Counters saturate rather than wrap.

## Timing
- Reset (asynchronous, while `reset` = 0):
  - `rows` = 4'b1110, `cmd` = 4'b1111, `cmd_valid` = 0, `key_down` = 0
  - state SCAN; all counters and synchronisers 0/idle (synchroniser idle = all ones).
- Reset assertion mid-EMIT forces `cmd` to NOP immediately (not clock-aligned). After release, a still-held key is rediscovered and emitted once.
- Frame length = 4·`SCAN_DIV` cycles (16 at defaults).
- Synchroniser latency is 2 cycles. `SCAN_DIV` ≥ 3 guarantees the sample sees settled columns for the driven row.
- Press latency (key stable before a frame start): `cmd_valid` rises on the cycle after the `DEBOUNCE`-th qualifying frame-end sample. At defaults this is ≤ 4 frames (64 cycles) after press.
- `cmd_valid` high for exactly `HOLD_CYCLES` consecutive cycles; `cmd` is stable throughout.
- Press and release are evaluated only at frame boundaries. A key released during EMIT does not shorten the burst.
- Minimum spacing between two emits: `HOLD_CYCLES` + `DEBOUNCE` release frames + `DEBOUNCE` press frames.

## Test plan
All scenarios use default parameters.
- Reset then hold key "1" (row0, col0 low while `rows[0]` = 0) for 100 cycles → exactly one burst: `cmd` = 4'd1 with `cmd_valid` = 1 for 10 cycles, starting ≤ 64 cycles after press; then `cmd` = 4'b1111.
- Press C, release, then press 3, release, then press # (each held 80 cycles, 80-cycle gaps) → bursts 4'b1100, 4'd3, 4'b1110 in order; `key_down` high for each press.
- Key "5" toggled every frame (bouncing) for 10 frames → no burst, `cmd_valid` stays 0; then held stable → one 4'd5 burst.
- Keys 2 and 6 held together for 10 frames → no burst. Release 6 while 2 stays held → one 4'd2 burst.
- Hold key D for 10 frames → `key_down` = 1, `cmd_valid` never asserts, `cmd` = 4'b1111 throughout.
- Hold "0", assert `reset` = 0 on the 4th cycle of EMIT → `cmd` = 4'b1111 and `cmd_valid` = 0 without waiting for a clock edge. After release of `reset` with "0" still held → exactly one new 4'd0 burst of 10 cycles.
